// File: rtl/alu_defs.sv
// alu_defs: definitions shared between the ALU decoder and the execute-stage ALU.
//   - ALU_* : the eight 3-bit ALUControl operation codes.
//   - state_t : exec_alu FSM state encoding.
package alu_defs;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_shifter.sv
// serial_shifter: iterative 1-bit-per-cycle logical shifter.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture load_data / load_amt / dir (has priority over en)
//   en          : perform one 1-bit shift step while the counter is non-zero
//   dir         : 0 = shift left (SLL), 1 = shift right logical (SRL)
//   load_data   : initial shift-register contents
//   load_amt    : number of 1-bit steps to perform
//   data_nxt    : shift-register contents after the step taken this cycle
//   done        : the step taken this cycle is the final one (counter == 1)
module serial_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_data,
    input  logic [SHW-1:0]   load_amt,
    output logic [WIDTH-1:0] data_nxt,
    output logic             done
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;

    // Zero is shifted in at the vacated end in both directions.
    assign data_nxt = dir_q ? {1'b0, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], 1'b0};

    // Exposing the last step lets the caller register the final value on
    // the same edge the counter empties, saving a cycle of latency.
    assign done = (cnt_q == SHW'(1));

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        if (load) begin
            data_d = load_data;
            cnt_d  = load_amt;
            dir_d  = dir;
        end else if (en && (cnt_q != '0)) begin
            data_d = data_nxt;
            cnt_d  = cnt_q - SHW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
        end
    end

endmodule

// File: rtl/exec_alu.sv
// exec_alu: execute-stage ALU with registered result and valid/ready handshake.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake; in_ready is high only in IDLE
//   ALUControl           : operation code (see alu_defs)
//   SrcA, SrcB           : operands; SrcB[SHW-1:0] is the shift amount
//   out_valid / out_ready: output handshake; out_valid is high only in DONE
//   ALUResult, Zero      : registered result and result-is-zero flag
// Single-cycle ops go IDLE -> DONE; SLL/SRL iterate in SHIFT, one bit per cycle.
module exec_alu
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] sh_nxt;
    logic             sh_done;

    logic signed [WIDTH-1:0] a_s, b_s;

    assign accept   = in_valid && (state_q == ST_IDLE);
    assign is_shift = (ALUControl == ALU_SLL) || (ALUControl == ALU_SRL);
    assign shamt    = SrcB[SHW-1:0];
    assign a_s      = SrcA;
    assign b_s      = SrcB;

    serial_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && is_shift),
        .en        (state_q == ST_SHIFT),
        .dir       (ALUControl == ALU_SRL),
        .load_data (SrcA),
        .load_amt  (shamt),
        .data_nxt  (sh_nxt),
        .done      (sh_done)
    );

    // Single-cycle arithmetic/logic; shift codes are handled by the shifter.
    always_comb begin
        alu_out = '0;
        case (ALUControl)
            ALU_ADD: alu_out = SrcA + SrcB;
            ALU_SUB: alu_out = SrcA - SrcB;
            ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_XOR: alu_out = SrcA ^ SrcB;
            ALU_OR:  alu_out = SrcA | SrcB;
            ALU_AND: alu_out = SrcA & SrcB;
            default: alu_out = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) state_d = ST_SHIFT;
                    else                           state_d = ST_DONE;
                end
            end
            ST_SHIFT: if (sh_done)   state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decode registered state only.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Result and Zero are written together from the same value.
    always_comb begin
        result_d = result_q;
        if (accept) begin
            if (is_shift) result_d = SrcA;
            else          result_d = alu_out;
        end else if ((state_q == ST_SHIFT) && sh_done) begin
            result_d = sh_nxt;
        end
        zero_d = (result_d == '0);
        if (!(accept && !(is_shift && (shamt != '0))) &&
            !((state_q == ST_SHIFT) && sh_done)) begin
            zero_d = zero_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_exec_alu.sv
module tb_exec_alu;
    import alu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;

    int checks = 0;
    int errors = 0;

    exec_alu #(.WIDTH(32), .SHW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, wait for the result and take it with out_ready high.
    task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        ALUControl = c; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 64) begin
            chk({tag, ".busy_in_ready"}, {31'd0, in_ready}, 32'd0);
            tick();
            cyc++;
        end
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".latency"}, cyc, lat);
        chk({tag, ".result"}, ALUResult, exp);
        chk({tag, ".zero"}, {31'd0, Zero}, {31'd0, (exp == 32'd0)});
        tick();
        chk({tag, ".after_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".after_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [2:0]  bb_c   [8];
    logic [31:0] bb_a   [8];
    logic [31:0] bb_b   [8];
    logic [31:0] bb_exp [8];
    int          acc_cyc[8];

    initial begin
        int idx_in, idx_out, cyc;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALUControl = ALU_ADD; SrcA = '0; SrcB = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result",    ALUResult,          32'd0);
        chk("rst.zero",      {31'd0, Zero},      32'd0);

        run_op("add",     ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
        run_op("add_wrap",ALU_ADD, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1);
        run_op("sub",     ALU_SUB, 32'd5, 32'd5, 32'h00000000, 1);
        run_op("sub_neg", ALU_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 1);
        run_op("slt",     ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 32'd1, 1);
        run_op("slt_sw",  ALU_SLT, 32'h00000001, 32'hFFFFFFFF, 32'd0, 1);
        run_op("xor",     ALU_XOR, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1);
        run_op("sll31",   ALU_SLL, 32'h00000001, 32'd31, 32'h80000000, 32);
        run_op("srl4",    ALU_SRL, 32'h80000000, 32'h000000E4, 32'h08000000, 5);
        run_op("sll0",    ALU_SLL, 32'h12345678, 32'h00000020, 32'h12345678, 1);
        run_op("sll3",    ALU_SLL, 32'h0000000F, 32'd3, 32'h00000078, 4);
        run_op("srl_z",   ALU_SRL, 32'h00000001, 32'd1, 32'h00000000, 2);

        // Backpressure: result held, in_valid pulses in DONE not captured.
        ALUControl = ALU_AND; SrcA = 32'hF0F0F0F0; SrcB = 32'hFF00FF00;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp.valid",  {31'd0, out_valid}, 32'd1);
            chk("bp.result", ALUResult, 32'hF000F000);
            in_valid = i[0]; ALUControl = ALU_ADD; SrcA = 32'd1; SrcB = 32'd1;
            tick();
        end
        chk("bp.held_result", ALUResult, 32'hF000F000);
        chk("bp.held_zero",   {31'd0, Zero}, 32'd0);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp.release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp.release_ready", {31'd0, in_ready},  32'd1);
        chk("bp.no_bypass",     ALUResult, 32'hF000F000);

        // Reset in the middle of a long shift.
        ALUControl = ALU_SLL; SrcA = 32'd1; SrcB = 32'd20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("rs.busy", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs.in_ready",  {31'd0, in_ready},  32'd1);
        chk("rs.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rs.result",    ALUResult,          32'd0);
        repeat (20) begin
            chk("rs.no_pulse", {31'd0, out_valid}, 32'd0);
            tick();
        end
        run_op("rs.or", ALU_OR, 32'h1, 32'h2, 32'h3, 1);

        // Back-to-back: in_valid held high, one op per code.
        bb_c[0] = ALU_ADD; bb_a[0] = 32'd3;         bb_b[0] = 32'd4;  bb_exp[0] = 32'd7;
        bb_c[1] = ALU_SUB; bb_a[1] = 32'd3;         bb_b[1] = 32'd4;  bb_exp[1] = 32'hFFFFFFFF;
        bb_c[2] = ALU_SLL; bb_a[2] = 32'd3;         bb_b[2] = 32'd2;  bb_exp[2] = 32'h0000000C;
        bb_c[3] = ALU_SLT; bb_a[3] = 32'd3;         bb_b[3] = 32'd4;  bb_exp[3] = 32'd1;
        bb_c[4] = ALU_XOR; bb_a[4] = 32'h0000FF00;  bb_b[4] = 32'h00FFFF00; bb_exp[4] = 32'h00FF0000;
        bb_c[5] = ALU_SRL; bb_a[5] = 32'h000000F0;  bb_b[5] = 32'd4;  bb_exp[5] = 32'h0000000F;
        bb_c[6] = ALU_OR;  bb_a[6] = 32'h00000100;  bb_b[6] = 32'h00000011; bb_exp[6] = 32'h00000111;
        bb_c[7] = ALU_AND; bb_a[7] = 32'h0000000C;  bb_b[7] = 32'h00000006; bb_exp[7] = 32'h00000004;
        idx_in = 0; idx_out = 0; cyc = 0;
        out_ready = 1'b1;
        ALUControl = bb_c[0]; SrcA = bb_a[0]; SrcB = bb_b[0]; in_valid = 1'b1;
        while (idx_out < 8 && cyc < 200) begin
            logic take;
            take = 1'b0;
            if (out_valid) begin
                chk($sformatf("bb%0d.result", idx_out), ALUResult, bb_exp[idx_out]);
                idx_out++;
            end
            if (in_ready && idx_in < 8) begin
                acc_cyc[idx_in] = cyc;
                take = 1'b1;
            end
            tick();
            cyc++;
            if (take) begin
                idx_in++;
                if (idx_in < 8) begin
                    ALUControl = bb_c[idx_in]; SrcA = bb_a[idx_in]; SrcB = bb_b[idx_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("bb.all_out", idx_out, 8);
        chk("bb.gap_add_sub", acc_cyc[1] - acc_cyc[0], 2);
        chk("bb.gap_sll",     acc_cyc[3] - acc_cyc[2], 4);
        chk("bb.gap_slt_xor", acc_cyc[4] - acc_cyc[3], 2);
        chk("bb.gap_or_and",  acc_cyc[7] - acc_cyc[6], 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
